// File: rtl/covid_key_pkg.sv
// rtl/covid_key_pkg.sv - shared types for the covid key event transmitter
// Purpose: key event byte layout, UART byte transmitter state encoding and the
//          debounce length used when g_simulation=1.
// Build option: KEY_TX_PARITY_EN adds the ST_PARITY state to t_tx_state.
package covid_key_pkg;

    localparam int c_SIM_DEBOUNCE = 16;

    typedef struct packed {
        logic       press;
        logic [2:0] rsvd;
        logic [3:0] idx;
    } t_key_event;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef KEY_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } t_tx_state;

endpackage

// File: rtl/covid_uart_tx_byte.sv
// rtl/covid_uart_tx_byte.sv - UART byte transmitter with valid/ready byte input
// Purpose: sends one byte per frame: start, 8 data bits LSB first, optional even
//          parity (KEY_TX_PARITY_EN), stop. Every bit lasts g_clk_div cycles.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous reset, active high
//   s_tdata_i   byte to send
//   s_tvalid_i  byte available
//   s_tready_o  byte taken this cycle (only in IDLE or at the end of STOP)
//   txd_o       registered serial line, idle high
//   busy_o      frame in progress
module covid_uart_tx_byte
    import covid_key_pkg::*;
#(
    parameter int g_clk_div = 104
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] s_tdata_i,
    input  logic       s_tvalid_i,
    output logic       s_tready_o,
    output logic       txd_o,
    output logic       busy_o
);

    localparam int              c_cw      = (g_clk_div > 1) ? $clog2(g_clk_div) : 1;
    localparam logic [c_cw-1:0] c_div_max = c_cw'(g_clk_div - 1);

    t_tx_state       state_q, state_d;
    logic [c_cw-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            txd_q, txd_d;
    logic            bit_end;
`ifdef KEY_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        s_tready_o = 1'b0;
`ifdef KEY_TX_PARITY_EN
        par_d      = par_q;
`endif
        bit_end = (cnt_q == c_div_max);
        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + c_cw'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (s_tvalid_i) begin
                    s_tready_o = 1'b1;
                    sh_d       = s_tdata_i;
`ifdef KEY_TX_PARITY_EN
                    par_d      = ^s_tdata_i;
`endif
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    sh_d  = {1'b0, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef KEY_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef KEY_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                // A waiting byte goes straight into START so consecutive
                // frames carry no idle gap after the stop bit.
                if (bit_end) begin
                    if (s_tvalid_i) begin
                        s_tready_o = 1'b1;
                        sh_d       = s_tdata_i;
`ifdef KEY_TX_PARITY_EN
                        par_d      = ^s_tdata_i;
`endif
                        state_d    = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level follows the next state so txd_o changes on the same
        // edge as the state register.
        unique case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = sh_d[0];
`ifdef KEY_TX_PARITY_EN
            ST_PARITY: txd_d = par_d;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
`ifdef KEY_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
`ifdef KEY_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign txd_o  = txd_q;
    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/covid_key_event_tx.sv
// rtl/covid_key_event_tx.sv - debounced front-panel key events sent as UART frames
// Purpose: synchronises and debounces g_num_keys buttons, turns each accepted
//          level change into a {press,000,idx} byte, queues it and transmits it.
// Build option: KEY_TX_PARITY_EN selects 8E1 frames instead of 8N1.
// Ports:
//   clk_sys_i    system clock
//   rst_i        synchronous reset, active high
//   keys_i       raw button levels, 1 = pressed
//   enable_i     0: level changes are tracked but not queued
//   ovf_clr_i    clears ovf_o (an overflow in the same cycle wins)
//   txd_o        UART line, idle high
//   busy_o       frame in progress or queue not empty
//   ovf_o        sticky event-dropped flag
//   key_state_o  debounced key levels
module covid_key_event_tx
    import covid_key_pkg::*;
#(
    parameter int g_num_keys        = 8,
    parameter int g_clk_div         = 104,
    parameter int g_debounce_cycles = 120000,
    parameter int g_fifo_depth      = 8,
    parameter int g_simulation      = 0
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_i,
    input  logic [g_num_keys-1:0] keys_i,
    input  logic                  enable_i,
    input  logic                  ovf_clr_i,
    output logic                  txd_o,
    output logic                  busy_o,
    output logic                  ovf_o,
    output logic [g_num_keys-1:0] key_state_o
);

    localparam int               c_db     = (g_simulation != 0) ? c_SIM_DEBOUNCE : g_debounce_cycles;
    localparam int               c_dbw    = (c_db > 1) ? $clog2(c_db) : 1;
    localparam logic [c_dbw-1:0] c_db_max = c_dbw'(c_db - 1);
    // Queue depth must be a power of two, at least 2.
    localparam int               c_aw     = (g_fifo_depth > 1) ? $clog2(g_fifo_depth) : 1;

    logic [g_num_keys-1:0] sync1_q, sync2_q;
    logic [g_num_keys-1:0] key_lvl_q, key_lvl_d;
    logic [g_num_keys-1:0] pend_q, pend_d;
    logic [g_num_keys-1:0] press_q, press_d;
    logic [c_dbw-1:0]      db_cnt_q [g_num_keys];
    logic [c_dbw-1:0]      db_cnt_d [g_num_keys];
    logic [g_num_keys-1:0] grant;

    t_key_event            evt;
    t_key_event            mem_q [g_fifo_depth];
    logic [c_aw:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  full, empty, push, drop, pop;
    logic                  ovf_q, ovf_d;
    logic                  tx_busy;
    logic [7:0]            head_byte;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                   (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);

    // Lowest pending index wins the single enqueue slot.
    assign grant = pend_q & (~pend_q + g_num_keys'(1));

    always_comb begin
        key_lvl_d = key_lvl_q;
        pend_d    = pend_q & ~grant;
        press_d   = press_q;
        evt       = '0;
        for (int k = 0; k < g_num_keys; k++) begin
            db_cnt_d[k] = db_cnt_q[k];
            if (grant[k]) begin
                evt.idx   = 4'(k);
                evt.press = press_q[k];
            end
        end
        push = (|pend_q) && !full;
        drop = (|pend_q) && full;

        // The counter runs while the synced level disagrees with the accepted
        // level and restarts whenever they agree again. A new flip overrides a
        // still-pending event of the same key, including one granted this cycle.
        for (int k = 0; k < g_num_keys; k++) begin
            if (sync2_q[k] != key_lvl_q[k]) begin
                if (db_cnt_q[k] == c_db_max) begin
                    db_cnt_d[k]  = '0;
                    key_lvl_d[k] = sync2_q[k];
                    if (enable_i) begin
                        pend_d[k]  = 1'b1;
                        press_d[k] = sync2_q[k];
                    end
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + c_dbw'(1);
                end
            end else begin
                db_cnt_d[k] = '0;
            end
        end

        wr_ptr_d = push ? wr_ptr_q + (c_aw+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (c_aw+1)'(1) : rd_ptr_q;

        ovf_d = ovf_q;
        if (ovf_clr_i) ovf_d = 1'b0;
        if (drop)      ovf_d = 1'b1;
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            key_lvl_q <= '0;
            pend_q    <= '0;
            press_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            for (int k = 0; k < g_num_keys; k++) db_cnt_q[k] <= '0;
        end else begin
            sync1_q   <= keys_i;
            sync2_q   <= sync1_q;
            key_lvl_q <= key_lvl_d;
            pend_q    <= pend_d;
            press_q   <= press_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            for (int k = 0; k < g_num_keys; k++) db_cnt_q[k] <= db_cnt_d[k];
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (push) mem_q[wr_ptr_q[c_aw-1:0]] <= evt;
    end

    assign head_byte = mem_q[rd_ptr_q[c_aw-1:0]];

    covid_uart_tx_byte #(
        .g_clk_div (g_clk_div)
    ) u_uart_tx (
        .clk_i      (clk_sys_i),
        .rst_i      (rst_i),
        .s_tdata_i  (head_byte),
        .s_tvalid_i (!empty),
        .s_tready_o (pop),
        .txd_o      (txd_o),
        .busy_o     (tx_busy)
    );

    assign busy_o      = tx_busy || !empty;
    assign ovf_o       = ovf_q;
    assign key_state_o = key_lvl_q;

endmodule

// File: tb/tb_covid_key_event_tx.sv
// tb/tb_covid_key_event_tx.sv - self-checking bench for covid_key_event_tx
module tb_covid_key_event_tx;

    localparam int NK  = 8;
    localparam int DIV = 8;
`ifdef KEY_TX_PARITY_EN
    localparam int NB  = 11;
`else
    localparam int NB  = 10;
`endif

    logic          clk       = 1'b0;
    logic          rst_i     = 1'b1;
    logic [NK-1:0] keys_i    = '0;
    logic          enable_i  = 1'b1;
    logic          ovf_clr_i = 1'b0;
    logic          txd_o;
    logic          busy_o;
    logic          ovf_o;
    logic [NK-1:0] key_state_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rst_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         start_q[$];

    covid_key_event_tx #(
        .g_num_keys        (NK),
        .g_clk_div         (DIV),
        .g_debounce_cycles (120000),
        .g_fifo_depth      (8),
        .g_simulation      (1)
    ) dut (
        .clk_sys_i   (clk),
        .rst_i       (rst_i),
        .keys_i      (keys_i),
        .enable_i    (enable_i),
        .ovf_clr_i   (ovf_clr_i),
        .txd_o       (txd_o),
        .busy_o      (busy_o),
        .ovf_o       (ovf_o),
        .key_state_o (key_state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_i) rst_cnt <= rst_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 30 && n < 5000) begin
            @(negedge clk);
            n++;
            quiet = busy_o ? 0 : quiet + 1;
        end
        check_eq("idle_reached", quiet, 30);
    endtask

    task automatic compare_frames(input string tag);
        int n;
        check_eq({tag, "_count"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq(tag, rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    // UART receiver: samples every cycle of every bit, so a bit that is not
    // exactly DIV cycles wide shows up as an unstable sample.
    initial begin
        logic [NB-1:0] bits;
        logic [7:0]    d;
        int            bad;
        int            r0;
        forever begin
            @(negedge clk);
            if (txd_o === 1'b0 && !rst_i) begin
                start_q.push_back(cyc);
                r0   = rst_cnt;
                bad  = 0;
                bits = '0;
                for (int b = 0; b < NB; b++) begin
                    for (int s = 0; s < DIV; s++) begin
                        if (!(b == 0 && s == 0)) @(negedge clk);
                        if (s == 0) bits[b] = txd_o;
                        else if (txd_o !== bits[b]) bad++;
                    end
                end
                if (rst_cnt == r0) begin
                    for (int i = 0; i < 8; i++) d[i] = bits[i+1];
`ifdef KEY_TX_PARITY_EN
                    check_eq("parity_bit", bits[9], ^d);
`endif
                    check_eq("stop_bit", bits[NB-1], 1);
                    check_eq("bit_width", bad, 0);
                    rx_q.push_back(d);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int            t0;
        int            n;
        int            hit;
        int            k;
        int            len;
        logic          en;
        logic [NK-1:0] model_lvl;

        tick(3);
        check_eq("rst_txd", txd_o, 1);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_ovf", ovf_o, 0);
        check_eq("rst_key_state", key_state_o, 0);
        rst_i = 1'b0;
        tick(5);

        // 1: key 3 press and release
        t0 = cyc;
        keys_i[3] = 1'b1;
        tick(20);
        check_eq("t1_key_state", key_state_o, 8'h08);
        check_eq("t1_busy", busy_o, 1);
        keys_i[3] = 1'b0;
        exp_q.push_back(8'h83);
        exp_q.push_back(8'h03);
        wait_idle();
        check_eq("t1_key_release", key_state_o, 0);
        check_eq("t1_latency", (start_q.size() > 0) ? start_q[0] - t0 : -1, 20);
        compare_frames("t1_frame");
        start_q.delete();

        // 2: too-short press is ignored
        keys_i[2] = 1'b1;
        tick(10);
        keys_i[2] = 1'b0;
        hit = 0;
        repeat (40) begin
            tick(1);
            if (key_state_o[2]) hit++;
        end
        wait_idle();
        check_eq("t2_key_state", hit, 0);
        check_eq("t2_starts", start_q.size(), 0);
        compare_frames("t2_frame");
        start_q.delete();

        // 3: simultaneous presses, back-to-back frames
        keys_i[1] = 1'b1;
        keys_i[5] = 1'b1;
        tick(25);
        keys_i[1] = 1'b0;
        keys_i[5] = 1'b0;
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h85);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h05);
        wait_idle();
        check_eq("t3_starts", start_q.size(), 4);
        for (int i = 1; i < start_q.size(); i++)
            check_eq("t3_gap", start_q[i] - start_q[i-1], NB * DIV);
        compare_frames("t3_frame");
        start_q.delete();

        // 4: 12 events against 1 in flight + 8 queued
        keys_i = 8'hFF;
        tick(25);
        keys_i = 8'hF0;
        tick(25);
        check_eq("t4_ovf_set", ovf_o, 1);
        ovf_clr_i = 1'b1;
        tick(1);
        ovf_clr_i = 1'b0;
        check_eq("t4_ovf_clr", ovf_o, 0);
        check_eq("t4_key_state", key_state_o, 8'hF0);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h80 | 8'(i));
        exp_q.push_back(8'h00);
        wait_idle();
        compare_frames("t4_frame");
        keys_i = 8'h00;
        for (int i = 4; i < 8; i++) exp_q.push_back(8'(i));
        tick(25);
        wait_idle();
        check_eq("t4_ovf_after", ovf_o, 0);
        compare_frames("t4_release");
        start_q.delete();

        // 5: reset during data bit 4
        keys_i[6] = 1'b1;
        tick(25);
        keys_i[6] = 1'b0;
        n = 0;
        while (start_q.size() == 0 && n < 200) begin
            tick(1);
            n++;
        end
        check_eq("t5_start_seen", start_q.size(), 1);
        if (start_q.size() > 0) begin
            while (cyc < start_q[0] + 5 * DIV + 3) tick(1);
        end
        check_eq("t5_data_bit4", txd_o, 0);
        rst_i = 1'b1;
        tick(1);
        check_eq("t5_txd_after_rst", txd_o, 1);
        check_eq("t5_busy_after_rst", busy_o, 0);
        rst_i = 1'b0;
        tick(300);
        check_eq("t5_starts", start_q.size(), 1);
        check_eq("t5_key_state", key_state_o, 0);
        compare_frames("t5_frame");
        start_q.delete();

        // Randomised phase: real toggles and short glitches, random enable.
        model_lvl = '0;
        for (int step = 0; step < 16; step++) begin
            k  = $urandom_range(0, NK-1);
            en = ($urandom_range(0, 3) != 0);
            enable_i = en;
            if ($urandom_range(0, 2) == 0) begin
                len = $urandom_range(1, 10);
                keys_i[k] = ~keys_i[k];
                tick(len);
                keys_i[k] = ~keys_i[k];
            end else begin
                keys_i[k]    = ~keys_i[k];
                model_lvl[k] = keys_i[k];
                if (en) exp_q.push_back({keys_i[k], 3'b000, 4'(k)});
            end
            tick($urandom_range(60, 120));
            check_eq("rnd_key_state", key_state_o, model_lvl);
        end
        enable_i = 1'b1;
        wait_idle();
        check_eq("rnd_ovf", ovf_o, 0);
        compare_frames("rnd_frame");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
